// File: rtl/uart_rx_ovs_pkg.sv
// uart_rx_ovs_pkg: shared state/parity types, limits and config helpers for the UART receiver
package uart_rx_ovs_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} rx_state_t;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;
    localparam int MIN_DATA_BITS = 5;
    localparam int DEF_OVS = 16;
    function automatic logic [3:0] clamp_bits(input logic [3:0] b, input int max_bits);
        return int'(b) < MIN_DATA_BITS ? 4'(MIN_DATA_BITS) : int'(b) > max_bits ? 4'(max_bits) : b;
    endfunction
    function automatic parity_t decode_parity(input logic [1:0] p);
        return p == 2'b01 ? PAR_EVEN : p == 2'b10 ? PAR_ODD : PAR_NONE;
    endfunction
endpackage

// File: rtl/uart_rx_ovs_if.sv
// uart_rx_ovs_if: valid/ready word channel with error sidebands out of the UART receiver
interface uart_rx_ovs_if #(parameter int MAX_DATA_BITS = 8);
    logic [MAX_DATA_BITS-1:0] m_data;
    logic m_par_err;
    logic m_frm_err;
    logic m_valid;
    logic m_ready;
    modport master(output m_data, m_par_err, m_frm_err, m_valid, input m_ready);
    modport slave(input m_data, m_par_err, m_frm_err, m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_ovs_baud_tick.sv
// uart_baud_tick: baud divider producing oversample ticks plus the per-bit oversample counter
module uart_baud_tick #(
    parameter int DIV_W = 16,
    parameter int OVS = 16
) (
    input  logic clk,
    input  logic arst_n,
    input  logic restart,
    input  logic [DIV_W-1:0] baud_div,
    output logic tick,
    output logic [$clog2(OVS)-1:0] os,
    output logic bit_end
);
    localparam int OSW = $clog2(OVS);
    logic [DIV_W-1:0] cnt;
    assign tick = cnt == baud_div;
    assign bit_end = tick && os == OSW'(OVS - 1);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
            os <= '0;
        end else if (restart) begin
            cnt <= '0;
            os <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
            if (tick) os <= bit_end ? '0 : os + OSW'(1);
        end
    end
endmodule

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampled UART receiver with majority voting, error/break detection and a one-word holding register
module uart_rx_ovs
    import uart_rx_ovs_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int DIV_W = 16,
    parameter int OVS = DEF_OVS
) (
    input  logic clk,
    input  logic arst_n,
    input  logic soft_rst,
    input  logic en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [3:0] cfg_data_bits,
    input  logic [1:0] cfg_parity,
    input  logic cfg_stop2,
    input  logic ovr_clr,
    input  logic rx_serial,
    uart_rx_ovs_if.master m,
    output logic overrun,
    output logic break_det,
    output logic busy
);
    localparam int OSW = $clog2(OVS);
    rx_state_t state, nxt;
    parity_t par_mode;
    logic [1:0] sync;
    logic [OSW-1:0] os;
    logic [3:0] nbits, bcnt;
    logic [MAX_DATA_BITS-1:0] shreg;
    logic rxs, rx_d, s0, s1, vote, tick, bit_end, vote_tick, start_det;
    logic stop2, sc, pbit, perr, frm, final_stop, brk, load;
    assign rxs = sync[1];
    assign vote = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign vote_tick = tick && os == OSW'(OVS / 2 + 1);
    assign start_det = state == IDLE && en && rx_d && !rxs;
    assign final_stop = state == STOP && vote_tick && sc == stop2;
    assign brk = final_stop && shreg == '0 && !pbit && !vote;
    assign load = final_stop && !brk && (!m.m_valid || m.m_ready);
    assign busy = state != IDLE;
    uart_baud_tick #(.DIV_W(DIV_W), .OVS(OVS)) u_tick (
        .clk, .arst_n, .restart(soft_rst || state == IDLE), .baud_div, .tick, .os, .bit_end
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = start_det ? START : IDLE;
            START:    nxt = (vote_tick && vote) ? IDLE : bit_end ? DATA : START;
            DATA:     nxt = (bit_end && bcnt == nbits) ? (par_mode == PAR_NONE ? STOP : PARITY) : DATA;
            PARITY:   nxt = bit_end ? STOP : PARITY;
            STOP:     nxt = final_stop ? (brk ? BRK_WAIT : IDLE) : STOP;
            BRK_WAIT: nxt = rxs ? IDLE : BRK_WAIT;
            default:  nxt = IDLE;
        endcase
        if (!en) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else state <= soft_rst ? IDLE : nxt;
    end
    // Data arrives LSB first into the MSB end; short words are right-aligned on load.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync <= 2'b11;
            rx_d <= 1'b1;
            {s0, s1, stop2, sc, pbit, perr, frm} <= '0;
            {nbits, bcnt, shreg} <= '0;
            par_mode <= PAR_NONE;
        end else if (soft_rst) begin
            sync <= 2'b11;
            rx_d <= 1'b1;
            {s0, s1, stop2, sc, pbit, perr, frm} <= '0;
            {nbits, bcnt, shreg} <= '0;
            par_mode <= PAR_NONE;
        end else begin
            sync <= {sync[0], rx_serial};
            rx_d <= rxs;
            if (tick && os == OSW'(OVS / 2 - 1)) s0 <= rxs;
            if (tick && os == OSW'(OVS / 2)) s1 <= rxs;
            if (start_det) begin
                nbits <= clamp_bits(cfg_data_bits, MAX_DATA_BITS);
                par_mode <= decode_parity(cfg_parity);
                stop2 <= cfg_stop2;
                {sc, pbit, perr, frm} <= '0;
                {bcnt, shreg} <= '0;
            end
            if (vote_tick && state == DATA) begin
                shreg <= {vote, shreg[MAX_DATA_BITS-1:1]};
                bcnt <= bcnt + 4'd1;
            end
            if (vote_tick && state == PARITY) begin
                pbit <= vote;
                perr <= ^shreg ^ vote ^ (par_mode == PAR_ODD);
            end
            if (vote_tick && state == STOP) frm <= frm | ~vote;
            if (bit_end && state == STOP) sc <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            {m.m_valid, m.m_par_err, m.m_frm_err, overrun, break_det} <= '0;
            m.m_data <= '0;
        end else if (soft_rst) begin
            {m.m_valid, m.m_par_err, m.m_frm_err, overrun, break_det} <= '0;
            m.m_data <= '0;
        end else begin
            m.m_valid <= load || (m.m_valid && !m.m_ready);
            if (load) begin
                m.m_data <= shreg >> (MAX_DATA_BITS - int'(nbits));
                m.m_par_err <= perr;
                m.m_frm_err <= frm | ~vote;
            end
            overrun <= (final_stop && !brk && !load) || (overrun && !ovr_clr);
            break_det <= brk;
        end
    end
endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: directed and randomized serial frames checked against a frame-level reference model
module tb_uart_rx_ovs;
    logic clk = 1'b0, arst_n = 1'b0, soft_rst = 1'b0, en = 1'b0;
    logic cfg_stop2 = 1'b0, ovr_clr = 1'b0, rx_serial = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic [3:0] cfg_data_bits = 4'd8;
    logic [1:0] cfg_parity = 2'd0;
    logic overrun, break_det, busy;
    int n_cmp = 0, n_bad = 0, n_brk = 0, div = 4;
    logic [9:0] got_q[$];
    uart_rx_ovs_if #(.MAX_DATA_BITS(8)) rx_if();
    uart_rx_ovs dut (
        .clk(clk), .arst_n(arst_n), .soft_rst(soft_rst), .en(en), .baud_div(baud_div),
        .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .ovr_clr(ovr_clr), .rx_serial(rx_serial), .m(rx_if), .overrun(overrun),
        .break_det(break_det), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rx_if.m_valid && rx_if.m_ready) got_q.push_back({rx_if.m_frm_err, rx_if.m_par_err, rx_if.m_data});
        if (break_det) n_brk++;
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic int clamp_nb(input int c);
        return c < 5 ? 5 : c > 8 ? 8 : c;
    endfunction
    function automatic bit par_bit(input logic [7:0] w, input int par, input bit flip);
        return (^w) ^ (par == 2) ^ flip;
    endfunction
    // Config inputs are scrambled after the start bit: the receiver must use the values seen at start.
    task automatic drive_frame(input logic [7:0] data, input int cfg_nb, input int par, input bit st2,
                               input bit flip, input logic [1:0] bad, input int gbit);
        int p = 16 * (div + 1);
        int nb = clamp_nb(cfg_nb);
        bit fb[$];
        cfg_data_bits = 4'(cfg_nb);
        cfg_parity = 2'(par);
        cfg_stop2 = st2;
        fb.push_back(1'b0);
        for (int i = 0; i < nb; i++) fb.push_back(data[i]);
        if (par == 1 || par == 2) fb.push_back(par_bit(data & 8'((1 << nb) - 1), par, flip));
        fb.push_back(!bad[0]);
        if (st2) fb.push_back(!bad[1]);
        foreach (fb[k]) begin
            if (k == gbit) begin
                rx_serial = 1'b1;
                cyc(8 * (div + 1) + 1);
                rx_serial = 1'b0;
                cyc(div + 1);
                rx_serial = 1'b1;
                cyc(p - 9 * (div + 1) - 1);
            end else begin
                rx_serial = fb[k];
                cyc(p);
            end
            if (k == 0) begin
                cfg_data_bits = 4'($urandom);
                cfg_parity = 2'($urandom);
                cfg_stop2 = 1'($urandom);
            end
        end
        rx_serial = 1'b1;
    endtask
    task automatic run_frame(input logic [7:0] data, input int cfg_nb, input int par, input bit st2,
                             input bit flip, input logic [1:0] bad, input int gbit);
        int nb = clamp_nb(cfg_nb);
        logic [7:0] word = data & 8'((1 << nb) - 1);
        bit haspar = par == 1 || par == 2;
        bit brk = word == 0 && (!haspar || !par_bit(word, par, flip)) && (st2 ? bad[1] : bad[0]);
        int brk0 = n_brk;
        logic [9:0] g;
        drive_frame(data, cfg_nb, par, st2, flip, bad, gbit);
        cyc(32 * (div + 1));
        check("words", got_q.size(), brk ? 0 : 1);
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            check("data", g[7:0], word);
            check("par_err", g[8], haspar && flip);
            check("frm_err", g[9], bad[0] || (st2 && bad[1]));
        end
        check("breaks", n_brk - brk0, brk);
        check("busy_idle", busy, 0);
        got_q.delete();
    endtask
    initial begin
        int p, b0;
        rx_if.m_ready = 1'b1;
        cyc(3);
        check("rst_valid", rx_if.m_valid, 0);
        check("rst_data", rx_if.m_data, 0);
        check("rst_errs", {rx_if.m_par_err, rx_if.m_frm_err}, 0);
        check("rst_flags", {overrun, break_det, busy}, 0);
        arst_n = 1'b1;
        en = 1'b1;
        cyc(20);
        p = 16 * (div + 1);
        run_frame(8'hA5, 8, 0, 0, 0, 2'b00, -1);
        run_frame(8'h35, 7, 1, 1, 1, 2'b00, -1);
        run_frame(8'h35, 7, 1, 1, 1, 2'b10, -1);
        rx_serial = 1'b0;
        cyc(3 * (div + 1));
        rx_serial = 1'b1;
        cyc(2 * p);
        check("glitch_busy", busy, 0);
        check("glitch_words", got_q.size(), 0);
        run_frame(8'h3C, 8, 0, 0, 0, 2'b00, -1);
        run_frame(8'hFF, 8, 0, 0, 0, 2'b00, 2);
        run_frame(8'h00, 8, 1, 0, 0, 2'b01, -1);
        for (int i = 0; i < 12; i++) begin
            div = $urandom_range(0, 4);
            baud_div = 16'(div);
            run_frame(8'($urandom), $urandom_range(3, 10), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00, -1);
        end
        div = 4;
        baud_div = 16'd4;
        b0 = n_brk;
        rx_serial = 1'b0;
        cyc(20 * p);
        rx_serial = 1'b1;
        cyc(2 * p);
        check("brk_pulses", n_brk - b0, 1);
        check("brk_words", got_q.size(), 0);
        check("brk_busy", busy, 0);
        run_frame(8'h5A, 8, 0, 0, 0, 2'b00, -1);
        rx_serial = 1'b0;
        cyc(3 * p / 2);
        check("abort_busy_pre", busy, 1);
        en = 1'b0;
        cyc(1);
        check("abort_busy", busy, 0);
        rx_serial = 1'b1;
        cyc(2);
        en = 1'b1;
        cyc(2 * p);
        check("abort_words", got_q.size(), 0);
        run_frame(8'h96, 8, 2, 1, 0, 2'b00, -1);
        rx_if.m_ready = 1'b0;
        drive_frame(8'h11, 8, 0, 0, 0, 2'b00, -1);
        cyc(2 * p);
        check("hold_valid", rx_if.m_valid, 1);
        check("hold_data", rx_if.m_data, 8'h11);
        drive_frame(8'h22, 8, 0, 0, 0, 2'b00, -1);
        cyc(2 * p);
        check("ovr_data", rx_if.m_data, 8'h11);
        check("ovr_set", overrun, 1);
        check("ovr_words", got_q.size(), 0);
        rx_if.m_ready = 1'b1;
        cyc(2);
        check("ovr_accept_n", got_q.size(), 1);
        if (got_q.size() > 0) check("ovr_accept_data", got_q.pop_front(), 10'h011);
        check("ovr_valid_low", rx_if.m_valid, 0);
        check("ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        cyc(1);
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        rx_if.m_ready = 1'b0;
        drive_frame(8'hC3, 8, 0, 0, 0, 2'b00, -1);
        cyc(2 * p);
        check("srst_pre_valid", rx_if.m_valid, 1);
        soft_rst = 1'b1;
        cyc(1);
        soft_rst = 1'b0;
        check("srst_valid", rx_if.m_valid, 0);
        check("srst_data", rx_if.m_data, 0);
        drive_frame(8'h77, 8, 0, 0, 0, 2'b00, -1);
        cyc(2 * p);
        rx_serial = 1'b0;
        cyc(p);
        check("arst_pre", {busy, rx_if.m_valid}, 2'b11);
        #2 arst_n = 1'b0;
        #1;
        check("arst_valid", rx_if.m_valid, 0);
        check("arst_data", rx_if.m_data, 0);
        check("arst_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
